// File: rtl/tdm_demux_4ch_pkg.sv
// Shared encodings for the 4-channel TDM receive link: FSM states and the
// slot numbers as the sending mux assigns them to channels.
package tdm_demux_4ch_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_C = 2'd1;
  localparam logic [1:0] SLOT_B = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demux_4ch.sv
// Receive side of the 4:1 TDM link: steps the slot select, gathers slot words
// into a shadow bank and commits a whole frame to A-D in one edge.
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             frame_done,
  output logic             sync_err
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] sh_q [4];
  logic [WIDTH-1:0] din_rev;
  logic             beat;
  logic             cap_start;
  logic             cap_next;
  logic             commit;
  logic             abort;

  assign beat = en & valid;
  assign sel  = slot_q;

  // The link sends words MSB-last, so every captured word is bit-reversed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign din_rev[i] = din[WIDTH-1-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (beat && sync) state_d = ST_COLLECT;
      ST_COLLECT: if (beat && !sync && slot_q == SLOT_D) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A sync beat always restarts at slot 0; in COLLECT it also aborts.
  always_comb begin
    cap_start = 1'b0;
    cap_next  = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    if (beat) begin
      if (sync) begin
        cap_start = 1'b1;
        abort     = (state_q == ST_COLLECT);
      end else if (state_q == ST_COLLECT) begin
        cap_next = 1'b1;
        commit   = (slot_q == SLOT_D);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= SLOT_A;
      for (int k = 0; k < 4; k++) sh_q[k] <= '0;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      D          <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (cap_start) begin
        sh_q[SLOT_A] <= din_rev;
        slot_q       <= SLOT_C;
      end else if (cap_next) begin
        sh_q[slot_q] <= din_rev;
        slot_q       <= slot_q + 2'd1;
      end
      // Last slot bypasses its shadow so the frame lands in a single edge.
      if (commit) begin
        A <= sh_q[SLOT_A];
        B <= sh_q[SLOT_B];
        C <= sh_q[SLOT_C];
        D <= din_rev;
      end
      frame_done <= commit;
      sync_err   <= abort;
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: reset, full frames, gaps, abort,
// back-to-back frames, enable pause and asynchronous reset mid-frame.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sync;
  logic       valid;
  logic [1:0] din;
  logic [1:0] sel;
  logic [1:0] A, B, C, D;
  logic       frame_done;
  logic       sync_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.WIDTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .valid      (valid),
    .din        (din),
    .sel        (sel),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic [1:0] ec, input logic [1:0] ed);
    chk({tag, ".A"}, {2'b0, A}, {2'b0, ea});
    chk({tag, ".B"}, {2'b0, B}, {2'b0, eb});
    chk({tag, ".C"}, {2'b0, C}, {2'b0, ec});
    chk({tag, ".D"}, {2'b0, D}, {2'b0, ed});
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] esel, input logic efd, input logic ese);
    chk({tag, ".sel"}, {2'b0, sel}, {2'b0, esel});
    chk({tag, ".frame_done"}, {3'b0, frame_done}, {3'b0, efd});
    chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, ese});
  endtask

  // Drive inputs just after an edge, then return 1 time unit after the next edge.
  task automatic step(input logic e, input logic v, input logic s, input logic [1:0] d);
    en = e; valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; valid = 1'b0; sync = 1'b0; din = 2'b00;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      chk_out("rst", 2'b00, 2'b00, 2'b00, 2'b00);
      chk_ctl("rst", 2'd0, 1'b0, 1'b0);
    end
    en = 1'b1; valid = 1'b0; sync = 1'b0; din = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 2'b00);
    chk_ctl("rel1", 2'd0, 1'b0, 1'b0);
    step(1, 0, 1, 2'b11);
    chk_ctl("rel2", 2'd0, 1'b0, 1'b0);

    // Normal frame: 01,10,11,00 -> A=10 C=01 B=11 D=00
    step(1, 1, 1, 2'b01); chk_ctl("f1s0", 2'd1, 1'b0, 1'b0);
    step(1, 1, 0, 2'b10); chk_ctl("f1s1", 2'd2, 1'b0, 1'b0);
    step(1, 1, 0, 2'b11); chk_ctl("f1s2", 2'd3, 1'b0, 1'b0);
    chk_out("f1pre", 2'b00, 2'b00, 2'b00, 2'b00);
    step(1, 1, 0, 2'b00); chk_ctl("f1s3", 2'd0, 1'b1, 1'b0);
    chk_out("f1", 2'b10, 2'b11, 2'b01, 2'b00);
    step(1, 0, 0, 2'b00); chk_ctl("f1idle", 2'd0, 1'b0, 1'b0);
    step(1, 1, 0, 2'b11); chk_ctl("f1nosync", 2'd0, 1'b0, 1'b0);
    chk_out("f1hold", 2'b10, 2'b11, 2'b01, 2'b00);

    // Same frame with a two-cycle gap after slot 1
    step(1, 1, 1, 2'b01);
    step(1, 1, 0, 2'b10); chk_ctl("g_s1", 2'd2, 1'b0, 1'b0);
    step(1, 0, 1, 2'b00); chk_ctl("g_gap1", 2'd2, 1'b0, 1'b0);
    step(1, 0, 0, 2'b01); chk_ctl("g_gap2", 2'd2, 1'b0, 1'b0);
    step(1, 1, 0, 2'b11); chk_ctl("g_s2", 2'd3, 1'b0, 1'b0);
    step(1, 1, 0, 2'b00); chk_ctl("g_s3", 2'd0, 1'b1, 1'b0);
    chk_out("gap", 2'b10, 2'b11, 2'b01, 2'b00);

    // Abort after two beats; restart with slot 0 = 00
    step(1, 1, 1, 2'b11);
    step(1, 1, 0, 2'b01); chk_ctl("ab_pre", 2'd2, 1'b0, 1'b0);
    step(1, 1, 1, 2'b00); chk_ctl("ab", 2'd1, 1'b0, 1'b1);
    chk_out("ab_hold", 2'b10, 2'b11, 2'b01, 2'b00);
    step(1, 0, 0, 2'b00); chk_ctl("ab_after", 2'd1, 1'b0, 1'b0);
    step(1, 1, 0, 2'b01);
    step(1, 1, 0, 2'b10);
    step(1, 1, 0, 2'b11); chk_ctl("ab_done", 2'd0, 1'b1, 1'b0);
    chk_out("ab_frame", 2'b00, 2'b01, 2'b10, 2'b11);

    // Back-to-back: X = 10,00,01,11 then Y = 11,10,00,01 with no gap
    step(1, 1, 1, 2'b10);
    step(1, 1, 0, 2'b00);
    step(1, 1, 0, 2'b01);
    step(1, 1, 0, 2'b11); chk_ctl("bx", 2'd0, 1'b1, 1'b0);
    chk_out("bx", 2'b01, 2'b10, 2'b00, 2'b11);
    step(1, 1, 1, 2'b11); chk_ctl("by0", 2'd1, 1'b0, 1'b0);
    step(1, 1, 0, 2'b10); chk_ctl("by1", 2'd2, 1'b0, 1'b0);
    step(1, 1, 0, 2'b00); chk_ctl("by2", 2'd3, 1'b0, 1'b0);
    step(1, 1, 0, 2'b01); chk_ctl("by3", 2'd0, 1'b1, 1'b0);
    chk_out("by", 2'b11, 2'b00, 2'b01, 2'b10);

    // Enable pause mid-frame: Z = 01,11,<pause>,10,00
    step(1, 1, 1, 2'b01);
    step(1, 1, 0, 2'b11); chk_ctl("ez_pre", 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, (i == 1), 2'($urandom));
      chk_ctl("ez_pause", 2'd2, 1'b0, 1'b0);
      chk_out("ez_pause", 2'b11, 2'b00, 2'b01, 2'b10);
    end
    step(1, 1, 0, 2'b10); chk_ctl("ez_s2", 2'd3, 1'b0, 1'b0);
    step(1, 1, 0, 2'b00); chk_ctl("ez_s3", 2'd0, 1'b1, 1'b0);
    chk_out("ez", 2'b10, 2'b01, 2'b11, 2'b00);

    // Asynchronous reset after three beats
    step(1, 1, 1, 2'b11);
    step(1, 1, 0, 2'b01);
    step(1, 1, 0, 2'b10); chk_ctl("ar_pre", 2'd3, 1'b0, 1'b0);
    en = 1'b1; valid = 1'b0; sync = 1'b0; din = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_now", 2'b00, 2'b00, 2'b00, 2'b00);
    chk_ctl("ar_now", 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 2'b00); chk_ctl("ar_b0", 2'd0, 1'b0, 1'b0);
    step(1, 1, 0, 2'b11); chk_ctl("ar_b1", 2'd0, 1'b0, 1'b0);
    chk_out("ar_b1", 2'b00, 2'b00, 2'b00, 2'b00);
    step(1, 1, 1, 2'b10); chk_ctl("ar_f0", 2'd1, 1'b0, 1'b0);
    step(1, 1, 0, 2'b01);
    step(1, 1, 0, 2'b11);
    step(1, 1, 0, 2'b00); chk_ctl("ar_f3", 2'd0, 1'b1, 1'b0);
    chk_out("ar_f", 2'b01, 2'b11, 2'b10, 2'b00);
    step(1, 0, 0, 2'b00); chk_ctl("ar_end", 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
